// File: rtl/fb_write_arbiter_if.sv
// Bundles the two requester streams and the framebuffer write port of fb_write_arbiter.
// The master side drives requests and observes ready and writes; the slave side is the arbiter.
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              fb_wr_en;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic [DATA_W-1:0] fb_wr_data;
  logic              idle;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  fb_wr_en, fb_wr_addr, fb_wr_data, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output fb_wr_en, fb_wr_addr, fb_wr_data, idle
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Merges two sprite-renderer pixel streams onto one framebuffer write port.
// Each requester has its own FIFO; a round-robin grant drains one entry per clock.
module fb_write_arbiter #(
  parameter int ADDR_W           = 19,
  parameter int DATA_W           = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter bit DROP_TRANSPARENT = 1'b1,
  parameter int TRANSPARENT_IDX  = 0
) (
  input logic                clock,
  input logic                fb_resetting,
  fb_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [2];
  logic [PTR_W-1:0]  rd_ptr [2];
  logic [CNT_W-1:0]  count [2];
  logic              last_grant;

  logic [1:0]        valid;
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        non_empty;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic              grant_any;
  logic              grant_sel;
  logic [ENT_W-1:0]  head;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Ready depends only on registered occupancy, so a full FIFO refuses a beat
  // even in a cycle where it is also being popped.
  always_comb begin
    valid      = {bus.req1_valid, bus.req0_valid};
    in_addr[0] = bus.req0_addr;
    in_addr[1] = bus.req1_addr;
    in_data[0] = bus.req0_data;
    in_data[1] = bus.req1_data;
    ready      = '0;
    push       = '0;
    non_empty  = '0;
    for (int i = 0; i < 2; i++) begin
      ready[i]     = !fb_resetting && (count[i] < CNT_W'(FIFO_DEPTH));
      non_empty[i] = (count[i] != '0);
      push[i]      = valid[i] && ready[i] &&
                     !(DROP_TRANSPARENT && (in_data[i] == DATA_W'(TRANSPARENT_IDX)));
    end
    grant_any = |non_empty;
    grant_sel = (&non_empty) ? !last_grant : non_empty[1];
    pop       = '0;
    if (grant_any) pop[grant_sel] = 1'b1;
    head      = mem[grant_sel][rd_ptr[grant_sel]];
  end

  always_ff @(posedge clock or posedge fb_resetting) begin
    if (fb_resetting) begin
      for (int i = 0; i < 2; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      last_grant <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      wr_en <= grant_any;
      if (grant_any) begin
        {wr_addr, wr_data} <= head;
        last_grant         <= grant_sel;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {in_addr[i], in_data[i]};
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.fb_wr_en   = wr_en;
  assign bus.fb_wr_addr = wr_addr;
  assign bus.fb_wr_data = wr_data;
  assign bus.idle       = (count[0] == '0) && (count[1] == '0) && !wr_en;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for contention, full FIFOs, asynchronous reset and draining.
module tb_fb_write_arbiter;
  logic clock = 1'b0;
  logic fb_resetting = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  fb_write_arbiter_if #(.ADDR_W(19), .DATA_W(4)) bus ();

  fb_write_arbiter dut (
    .clock        (clock),
    .fb_resetting (fb_resetting),
    .bus          (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v0;
    logic [18:0] a0;
    logic [3:0]  d0;
    logic        v1;
    logic [18:0] a1;
    logic [3:0]  d1;
    logic        en;
    logic [18:0] addr;
    logic [3:0]  data;
    logic        r0;
    logic        r1;
    logic        idle;
  } vec_t;

  vec_t vecs [19];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v0, input logic [18:0] a0, input logic [3:0] d0,
                                input logic v1, input logic [18:0] a1, input logic [3:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
  endtask

  // Records which beats are accepted at the coming edge, then settles just after it.
  task automatic tick(output logic acc0, output logic acc1);
    acc0 = bus.req0_valid && bus.req0_ready;
    acc1 = bus.req1_valid && bus.req1_ready;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic acc0, acc1, prev_r0, prev_r1, done;
    int   i0, i1, cnt0, cnt1, n_wr, expected_writes, writes;

    apply_stimulus(0, 0, 0, 0, 0, 0);

    // addresses 100..103 streaming, transparent drop on req1, then a two-way contest
    vecs[0]  = '{1, 19'd100,  4'd5, 0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 1, 0};
    vecs[1]  = '{1, 19'd101,  4'd5, 0, 19'd0,    4'd0, 1, 19'd100,  4'd5, 1, 1, 0};
    vecs[2]  = '{1, 19'd102,  4'd5, 0, 19'd0,    4'd0, 1, 19'd101,  4'd5, 1, 1, 0};
    vecs[3]  = '{1, 19'd103,  4'd5, 0, 19'd0,    4'd0, 1, 19'd102,  4'd5, 1, 1, 0};
    vecs[4]  = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 19'd103,  4'd5, 1, 1, 0};
    vecs[5]  = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 1, 1};
    vecs[6]  = '{0, 19'd0,    4'd0, 1, 19'd1,    4'd0, 0, 19'd0,    4'd0, 1, 1, 1};
    vecs[7]  = '{0, 19'd0,    4'd0, 1, 19'd2,    4'd3, 0, 19'd0,    4'd0, 1, 1, 0};
    vecs[8]  = '{0, 19'd0,    4'd0, 1, 19'd3,    4'd0, 1, 19'd2,    4'd3, 1, 1, 0};
    vecs[9]  = '{0, 19'd0,    4'd0, 1, 19'd4,    4'd7, 0, 19'd0,    4'd0, 1, 1, 0};
    vecs[10] = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 19'd4,    4'd7, 1, 1, 0};
    vecs[11] = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 1, 1};
    vecs[12] = '{1, 19'h30,   4'd1, 1, 19'h40,   4'd2, 0, 19'd0,    4'd0, 1, 1, 0};
    vecs[13] = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 19'h30,   4'd1, 1, 1, 0};
    vecs[14] = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 19'h40,   4'd2, 1, 1, 0};
    vecs[15] = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 1, 1};
    vecs[16] = '{1, 19'h50,   4'd6, 0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 1, 0};
    vecs[17] = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 19'h50,   4'd6, 1, 1, 0};
    vecs[18] = '{0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 0, 19'd0,    4'd0, 1, 1, 1};

    #2;
    check_output("reset_wr_en", 32'(bus.fb_wr_en), 0);
    check_output("reset_wr_addr", 32'(bus.fb_wr_addr), 0);
    check_output("reset_ready0", 32'(bus.req0_ready), 0);
    check_output("reset_ready1", 32'(bus.req1_ready), 0);
    check_output("reset_idle", 32'(bus.idle), 1);
    #20 fb_resetting = 1'b0;
    @(posedge clock);
    #1;

    for (int k = 0; k < 19; k++) begin
      apply_stimulus(vecs[k].v0, vecs[k].a0, vecs[k].d0, vecs[k].v1, vecs[k].a1, vecs[k].d1);
      tick(acc0, acc1);
      check_output($sformatf("vec%0d_wr_en", k), 32'(bus.fb_wr_en), 32'(vecs[k].en));
      if (vecs[k].en) begin
        check_output($sformatf("vec%0d_addr", k), 32'(bus.fb_wr_addr), 32'(vecs[k].addr));
        check_output($sformatf("vec%0d_data", k), 32'(bus.fb_wr_data), 32'(vecs[k].data));
      end
      check_output($sformatf("vec%0d_ready0", k), 32'(bus.req0_ready), 32'(vecs[k].r0));
      check_output($sformatf("vec%0d_ready1", k), 32'(bus.req1_ready), 32'(vecs[k].r1));
      check_output($sformatf("vec%0d_idle", k), 32'(bus.idle), 32'(vecs[k].idle));
    end

    // Reset pulse away from the edge; last_grant was left on requester 0
    #2 fb_resetting = 1'b1;
    #1;
    check_output("pulse_wr_en", 32'(bus.fb_wr_en), 0);
    check_output("pulse_idle", 32'(bus.idle), 1);
    #3 fb_resetting = 1'b0;
    @(posedge clock);
    #1;

    // Contention: strict alternation starting with requester 0, occupancy tracked from traffic
    i0 = 0; i1 = 0; cnt0 = 0; cnt1 = 0; n_wr = 0; prev_r0 = 1'b0; prev_r1 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      apply_stimulus(1, 19'(32'h10 + i0), 4'h5, 1, 19'(32'h200 + i1), 4'hA);
      check_output("full_ready0", 32'(bus.req0_ready), 32'(cnt0 < 4));
      check_output("full_ready1", 32'(bus.req1_ready), 32'(cnt1 < 4));
      if (c >= 10) begin
        check_output("toggle_ready0", 32'(bus.req0_ready), 32'(!prev_r0));
        check_output("toggle_ready1", 32'(bus.req1_ready), 32'(!prev_r1));
      end
      prev_r0 = bus.req0_ready;
      prev_r1 = bus.req1_ready;
      tick(acc0, acc1);
      if (acc0) begin i0++; cnt0++; end
      if (acc1) begin i1++; cnt1++; end
      check_output("contend_wr_en", 32'(bus.fb_wr_en), (c == 0) ? 0 : 1);
      if (bus.fb_wr_en) begin
        check_output("contend_addr", 32'(bus.fb_wr_addr),
                     (n_wr % 2 == 0) ? 32'h10 + n_wr / 2 : 32'h200 + n_wr / 2);
        check_output("contend_data", 32'(bus.fb_wr_data), (n_wr % 2 == 0) ? 32'h5 : 32'hA);
        if (bus.fb_wr_addr < 19'h200) cnt0--; else cnt1--;
        n_wr++;
      end
    end

    // Asynchronous reset while both FIFOs are loaded and valids stay high
    #3 fb_resetting = 1'b1;
    #1;
    check_output("midreset_wr_en", 32'(bus.fb_wr_en), 0);
    check_output("midreset_ready0", 32'(bus.req0_ready), 0);
    check_output("midreset_ready1", 32'(bus.req1_ready), 0);
    check_output("midreset_idle", 32'(bus.idle), 1);
    repeat (2) @(posedge clock);
    #1;
    check_output("held_reset_wr_en", 32'(bus.fb_wr_en), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    #2 fb_resetting = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(acc0, acc1);
      check_output("post_reset_wr_en", 32'(bus.fb_wr_en), 0);
      check_output("post_reset_ready0", 32'(bus.req0_ready), 1);
      check_output("post_reset_ready1", 32'(bus.req1_ready), 1);
      check_output("post_reset_idle", 32'(bus.idle), 1);
    end

    // Mixed traffic with transparent beats, then drain
    expected_writes = 0;
    writes = 0;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1, 19'(32'h300 + k), (k % 3 == 0) ? 4'd0 : 4'(k),
                     (k % 2 == 0), 19'(32'h400 + k), (k % 4 == 0) ? 4'd0 : 4'(k + 1));
      tick(acc0, acc1);
      if (acc0 && (k % 3 != 0)) expected_writes++;
      if (acc1 && (k % 4 != 0)) expected_writes++;
      if (bus.fb_wr_en) writes++;
    end
    apply_stimulus(0, 0, 0, 0, 0, 0);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick(acc0, acc1);
      if (bus.fb_wr_en) begin
        writes++;
        check_output("drain_busy_idle", 32'(bus.idle), 0);
      end else begin
        check_output("drain_idle", 32'(bus.idle), 1);
        done = 1'b1;
      end
    end
    check_output("drain_finished", 32'(done), 1);
    check_output("drain_write_count", 32'(writes), 32'(expected_writes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
